// File: rtl/jar_sram_host_if.sv
// jar_sram_host_if: byte request / response handshake between on-chip logic and the SRAM host
interface jar_sram_host_if #(parameter int AW = 4, parameter int DW = 8);
  logic req_valid, req_ready, req_write, rsp_valid;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, rsp_rdata;
  modport master (output req_valid, req_write, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata);
  modport slave (input req_valid, req_write, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/jar_sram_host.sv
// jar_sram_host: sequences byte read/write requests onto the nibble-serial SRAM pin protocol
module jar_sram_host #(
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int HALF = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  jar_sram_host_if.slave bus,
  output logic          sram_clk,
  output logic          sram_rst,
  output logic          sram_we,
  output logic          sram_oe,
  output logic [AW-1:0] sram_ad,
  input  logic [DW-1:0] sram_dout
);
  localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
  typedef enum logic [2:0] {INIT, IDLE, WR, RD, RD_CAP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] tick, tick_d;
  logic [AW-1:0] addr_q, addr_d, ad_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_d;
  logic clk_d, srst_d, we_d, oe_d, rsp_d, phase_end;
  assign phase_end = cnt == CW'(HALF - 1);
  // Pins only move at the end of a HI phase (start of LO), so the SRAM sees them stable at the rise
  always_comb begin
    state_d = state;
    cnt_d = phase_end ? '0 : cnt + CW'(1);
    tick_d = tick;
    addr_d = addr_q;
    wdata_d = wdata_q;
    clk_d = sram_clk;
    srst_d = sram_rst;
    we_d = sram_we;
    oe_d = sram_oe;
    ad_d = sram_ad;
    rdata_d = bus.rsp_rdata;
    rsp_d = 1'b0;
    case (state)
      INIT: if (phase_end) begin
        clk_d = ~sram_clk;
        srst_d = ~sram_clk;
        state_d = sram_clk ? IDLE : INIT;
      end
      IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          wdata_d = bus.req_wdata;
          tick_d = '0;
          we_d = bus.req_write;
          oe_d = ~bus.req_write;
          ad_d = bus.req_write ? bus.req_wdata[AW-1:0] : bus.req_addr;
          state_d = bus.req_write ? WR : RD;
        end
      end
      WR: if (phase_end) begin
        clk_d = ~sram_clk;
        if (sram_clk) begin
          tick_d = tick + 2'd1;
          ad_d = tick == 2'd0 ? wdata_q[DW-1:AW] : tick == 2'd1 ? addr_q : '0;
          we_d = tick != 2'd2;
          rsp_d = tick == 2'd2;
          state_d = tick == 2'd2 ? IDLE : WR;
        end
      end
      RD: if (phase_end) begin
        clk_d = ~sram_clk;
        state_d = sram_clk ? RD_CAP : RD;
      end
      RD_CAP: if (phase_end) begin
        rdata_d = sram_dout;
        oe_d = 1'b0;
        ad_d = '0;
        rsp_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      tick <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      sram_clk <= 1'b0;
      sram_rst <= 1'b1;
      sram_we <= 1'b0;
      sram_oe <= 1'b0;
      sram_ad <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      tick <= tick_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      sram_clk <= clk_d;
      sram_rst <= srst_d;
      sram_we <= we_d;
      sram_oe <= oe_d;
      sram_ad <= ad_d;
      bus.req_ready <= state_d == IDLE;
      bus.rsp_valid <= rsp_d;
      bus.rsp_rdata <= rdata_d;
    end
endmodule
